// File: rtl/shift_sched_pkg.sv
// ============================================================================
//  Module   : shift_sched_pkg
//  Purpose  : Shared types and round-robin pick function for shift_rr_scheduler.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package shift_sched_pkg;

    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of valid at or after ptr, wrapping at nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 nreq);
        pick_t            p;
        int               j;
        logic [IDX_W-1:0] jj;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= nreq) j = j - nreq;
            jj = IDX_W'(j);
            if (k < nreq && !p.found && valid[jj]) begin
                p.found = 1'b1;
                p.idx   = jj;
            end
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/NbitBarrelShifter.sv
// ============================================================================
//  Module   : NbitBarrelShifter
//  Purpose  : Rotate-right of an N-bit word by shiftAmt modulo N.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module NbitBarrelShifter #(
    parameter int N  = 8,
    parameter int AW = 8
) (
    input  logic [N-1:0]  din,
    input  logic [AW-1:0] shiftAmt,
    output logic [N-1:0]  dout
);

    logic [AW-1:0]  w_rem;
    logic [2*N-1:0] w_dbl;

    assign w_rem = shiftAmt % AW'(N);
    assign w_dbl = {din, din};
    assign dout  = N'(w_dbl >> w_rem);

endmodule

`default_nettype wire

// File: rtl/shift_rr_scheduler_picker.sv
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin picker over NREQ valid bits.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_picker
    import shift_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            found
);

    pick_t w_pick;

    assign w_pick = rr_pick(MAX_REQ'(valid), IDX_W'(ptr), NREQ);
    assign idx    = IW'(w_pick.idx);
    assign found  = w_pick.found;

endmodule

`default_nettype wire

// File: rtl/shift_rr_scheduler.sv
// ============================================================================
//  Module   : shift_rr_scheduler
//  Purpose  : Round-robin sharing of one barrel shifter among NREQ requesters.
//             SHIFT_SCHED_PRIO_EN gives requester 0 absolute priority.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module shift_rr_scheduler
    import shift_sched_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int AW   = 8,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_data,
    input  logic [NREQ*AW-1:0] req_amt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_data,
    output logic [IW-1:0]     rsp_id
);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_rr_ptr;
    logic [N-1:0]    r_op_data;
    logic [AW-1:0]   r_op_amt;
    logic [IW-1:0]   r_op_id;
    logic            r_rsp_valid;
    logic [N-1:0]    r_rsp_data;
    logic [IW-1:0]   r_rsp_id;

    logic [NREQ-1:0] w_pick_valid;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_found;
    logic [IW-1:0]   w_grant;
    logic            w_any;
    logic            w_accept;
    logic            w_handshake;
    logic [IW-1:0]   w_ptr_next;
    logic [N-1:0]    w_shift_out;
    logic [N-1:0]    w_data_arr [NREQ];
    logic [AW-1:0]   w_amt_arr  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign w_data_arr[i] = req_data[i*N +: N];
        assign w_amt_arr[i]  = req_amt[i*AW +: AW];
    end

    assign w_any = |req_valid;

`ifdef SHIFT_SCHED_PRIO_EN
    // Requester 0 is taken out of the rotation and overrides it when valid.
    assign w_pick_valid = req_valid & ~NREQ'(1);
    assign w_grant      = req_valid[0] ? '0 : w_pick_idx;
    assign w_ptr_next   = (r_op_id == '0) ? r_rr_ptr :
                          (r_op_id == IW'(NREQ-1)) ? '0 : r_op_id + IW'(1);
`else
    assign w_pick_valid = req_valid;
    assign w_grant      = w_pick_idx;
    assign w_ptr_next   = (r_op_id == IW'(NREQ-1)) ? '0 : r_op_id + IW'(1);
`endif

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .valid (w_pick_valid),
        .ptr   (r_rr_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    NbitBarrelShifter #(
        .N  (N),
        .AW (AW)
    ) u_shifter (
        .din      (r_op_data),
        .shiftAmt (r_op_amt),
        .dout     (w_shift_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any && !reset) begin
                    req_ready = NREQ'(1) << w_grant;
                    w_accept  = 1'b1;
                    w_next    = EXEC;
                end
            end
            EXEC: w_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_handshake = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_op_data   <= '0;
            r_op_amt    <= '0;
            r_op_id     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            if (w_accept) begin
                r_op_data <= w_data_arr[w_grant];
                r_op_amt  <= w_amt_arr[w_grant];
                r_op_id   <= w_grant;
            end
            if (r_state == EXEC) begin
                r_rsp_data  <= w_shift_out;
                r_rsp_id    <= r_op_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_rsp_valid <= 1'b0;
                r_rr_ptr    <= w_ptr_next;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;

endmodule

`default_nettype wire

// File: tb/tb_shift_rr_scheduler.sv
// ============================================================================
//  Module   : tb_shift_rr_scheduler
//  Purpose  : Directed self-checking bench for shift_rr_scheduler (N=8, NREQ=4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shift_rr_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [31:0] req_amt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_gcyc = 0;

    // Rotate-right results of the per-requester table loaded in the fairness test.
    logic [7:0] exp_rot [4] = '{8'h11, 8'h11, 8'hCC, 8'h88};
`ifdef SHIFT_SCHED_PRIO_EN
    int ord_all [5] = '{0, 0, 0, 0, 0};
    int ord_bp  [2] = '{0, 0};
    int ord_02  [3] = '{0, 0, 0};
`else
    int ord_all [5] = '{0, 1, 2, 3, 0};
    int ord_bp  [2] = '{1, 2};
    int ord_02  [3] = '{2, 0, 2};
`endif

    shift_rr_scheduler #(.N(8), .NREQ(4), .AW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_amt   (req_amt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic [7:0] a);
        req_data[i*8 +: 8] = d;
        req_amt[i*8 +: 8]  = a;
    endtask

    // One full operation: grant, EXEC, response, optional backpressure, handshake.
    task automatic do_op(input int g, input logic [7:0] d, input bit spacing, input int hold);
        int w;
        w = 0;
        #1;
        while (req_ready == 4'd0 && w < 12) begin
            tick();
            #1;
            w++;
        end
        check("grant", {28'd0, req_ready}, 32'd1 << g);
        if (spacing) check("grant_spacing", cyc - last_gcyc, 3);
        last_gcyc = cyc;
        tick();
        check("exec_ready", {28'd0, req_ready}, 0);
        check("exec_valid", {31'd0, rsp_valid}, 0);
        tick();
        check("rsp_valid", {31'd0, rsp_valid}, 1);
        check("rsp_id", {30'd0, rsp_id}, g);
        check("rsp_data", {24'd0, rsp_data}, {24'd0, d});
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_valid", {31'd0, rsp_valid}, 1);
            check("hold_id", {30'd0, rsp_id}, g);
            check("hold_data", {24'd0, rsp_data}, {24'd0, d});
            check("hold_no_grant", {28'd0, req_ready}, 0);
        end
        rsp_ready = 1'b1;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_amt   = '0;
        rsp_ready = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'($urandom);
            req_data  = $urandom;
            req_amt   = $urandom;
            rsp_ready = 1'($urandom);
            tick();
            check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
            check("rst_req_ready", {28'd0, req_ready}, 0);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        req_data  = '0;
        req_amt   = '0;
        reset     = 1'b0;
        tick();
        check("idle_req_ready", {28'd0, req_ready}, 0);
        check("idle_rsp_valid", {31'd0, rsp_valid}, 0);
        check("idle_rsp_data", {24'd0, rsp_data}, 0);
        check("idle_rsp_id", {30'd0, rsp_id}, 0);

        // Single ops, amount wrap and zero amount
        rsp_ready = 1'b1;
        set_req(0, 8'h81, 8'd1);
        req_valid = 4'b0001;
        do_op(0, 8'hC0, 1'b0, 0);
        set_req(0, 8'h81, 8'd9);
        do_op(0, 8'hC0, 1'b0, 0);
        set_req(0, 8'h81, 8'd0);
        do_op(0, 8'h81, 1'b0, 0);
        req_valid = 4'b0100;
        set_req(2, 8'h0F, 8'd4);
        do_op(2, 8'hF0, 1'b0, 0);
        req_valid = '0;

        // Fairness with all requesters valid, from a fresh rr_ptr
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_req(0, 8'h11, 8'd0);
        set_req(1, 8'h22, 8'd1);
        set_req(2, 8'h33, 8'd2);
        set_req(3, 8'h44, 8'd3);
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) do_op(ord_all[g], exp_rot[ord_all[g]], g > 0, 0);

        // Backpressure: response held 10 cycles, next grant right after handshake
        rsp_ready = 1'b0;
        do_op(ord_bp[0], exp_rot[ord_bp[0]], 1'b0, 10);
        check("post_hs_grant", {28'd0, req_ready}, 32'd1 << ord_bp[1]);
        check("post_hs_valid", {31'd0, rsp_valid}, 0);
        req_valid = '0;
        tick();

        // Reset asserted while in EXEC discards the op
        req_valid = 4'b1111;
        tick();
        reset = 1'b1;
        #1;
        check("rst_exec_valid", {31'd0, rsp_valid}, 0);
        tick();
        reset     = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_rsp_after_rst", {31'd0, rsp_valid}, 0);
        end
        req_valid = 4'b1111;
        do_op(0, exp_rot[0], 1'b0, 0);

        // Requesters 0 and 2 contending
        req_valid = 4'b0101;
        for (int g = 0; g < 3; g++) do_op(ord_02[g], exp_rot[ord_02[g]], g > 0, 0);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
